qpix_serial_readback: RTL
=========================

Name: qpix_serial_readback

Overview:
- Reads back the QPix configuration/status shift register over the serial readback interface.
- Counterpart of the existing serial load path: the load path shifts a 32-bit word into the ASIC with a gated clock; this block reads a word out of the ASIC.
- Sequence: a single preload CLKin2 pulse, then assert serialOutCnt, then NBITS CLKin2 pulses while sampling the ASIC serial output MSB-first, then deassert and present the word.
- Sits in top_rtl beside each serial interface. One instance per interface (interface 1 and interface 2), started from a reg_rw bit; the result is returned to a read register.

Parameters:
- NBITS, 32, number of bits shifted out of the ASIC per readback.
- CLK_HALF, 5, CLKin2 high-phase and low-phase length in clk cycles; legal range 3..255.
- SETUP_CYC, 10, clk cycles between serialOutCnt rising and the first shift pulse; legal range 1..1023.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst, input, 1, synchronous active-high reset.
- start, input, 1, level or pulse; a rising edge (detected internally) launches one readback.
- serial_din, input, 1, ASIC serial output; asynchronous to clk.
- clkin2, output, 1, generated CLKin2 to the ASIC; registered, glitch-free.
- serial_out_cnt, output, 1, serialOutCnt to the ASIC.
- data_out, output, NBITS, last captured word, MSB = first bit received.
- data_valid, output, 1, one-cycle strobe when data_out updates.
- busy, output, 1, high from the cycle after the start edge through the data_valid cycle inclusive.

Behaviour:
- Reset values: clkin2=0, serial_out_cnt=0, data_out=0, data_valid=0, busy=0, state=IDLE. The start-edge register is cleared to 0.
- Reset mid-operation takes effect in 1 cycle. Any partial word is discarded and no data_valid is issued.
- serial_din passes through a 2-FF synchronizer; its reset value is 0.
- Start detection:
  - An edge is start=1 with start_d=0.
  - An edge while busy=1 is ignored and not queued.
  - An edge arriving in the same cycle as data_valid is also ignored.
- IDLE: on a start edge in cycle t, move to PRE at t+1.
- PRE: clkin2=1 for CLK_HALF cycles, then 0 for CLK_HALF cycles. serial_out_cnt stays 0. Then go to SETUP.
- SETUP: serial_out_cnt=1, clkin2=0 for SETUP_CYC cycles. Then go to SHIFT.
- SHIFT: NBITS pulses, each CLK_HALF cycles high then CLK_HALF cycles low.
  - serial_out_cnt stays 1.
  - The ASIC updates its output on the CLKin2 rising edge.
  - The synchronized serial_din is sampled on the last clk cycle of each low phase and shifted in: shreg <= {shreg[NBITS-2:0], din_sync}.
  - A bit counter (width clog2(NBITS+1)) counts the sampled bits. After sample NBITS the block goes to DONE.
- DONE (1 cycle): data_out <= shreg, data_valid=1, serial_out_cnt=0, clkin2=0. Next cycle: IDLE with busy=0.
- Latency: data_valid is asserted exactly 1 + 2·CLK_HALF + SETUP_CYC + 2·CLK_HALF·NBITS cycles after the start-edge cycle. With defaults this is 341 cycles.
- clkin2 produces exactly NBITS+1 rising edges per readback, 33 by default. It never toggles in IDLE, SETUP or DONE.
- serial_out_cnt is never high while a PRE pulse is in progress.
- data_out holds its value between readbacks and changes only in DONE or on reset.

Test Plan:
- Bench ASIC model loaded with 0xA5A5F00F, shifting MSB-first on clkin2 rise; start pulse at defaults -> data_valid exactly 341 cycles after the start edge; data_out=0xA5A5F00F; busy low the next cycle.
- Count clkin2 rising edges across one readback -> exactly 33. Exactly 1 edge occurs while serial_out_cnt=0, and serial_out_cnt is high for 10 cycles before the 2nd edge.
- Two start edges, at cycle 100 and at cycle 50 of busy -> exactly one data_valid. After a new model word 0x12345678 and a third start following idle, data_out=0x12345678.
- Assert rst for 1 cycle at bit 16 of SHIFT -> the next cycle clkin2=0, serial_out_cnt=0, busy=0, data_out=0, and no data_valid. A subsequent start returns the full correct word.
- Parameter sweep CLK_HALF=3, SETUP_CYC=1, NBITS=8 with model word 0x81 -> data_valid at 1+6+1+48=56 cycles; data_out=0x81.
- Back-to-back: hold start high for 400 cycles -> exactly one readback. Releasing start and raising it again -> a second readback with identical timing.

Source files
------------

// File: rtl/qpix_serial_readback.sv
// Serial readback of the QPix configuration/status shift register.
// Issues one preload CLKin2 pulse, raises serialOutCnt, then clocks NBITS bits out MSB-first.
module qpix_serial_readback #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned CLK_HALF  = 5,
    parameter int unsigned SETUP_CYC = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             serial_din,
    output logic             clkin2,
    output logic             serial_out_cnt,
    output logic [NBITS-1:0] data_out,
    output logic             data_valid,
    output logic             busy
);

    localparam int unsigned PER     = 2 * CLK_HALF;
    localparam int unsigned CNT_MAX = (PER > SETUP_CYC) ? PER : SETUP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam int unsigned BIT_W   = $clog2(NBITS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bitcnt;
    logic [NBITS-1:0] r_shreg;
    logic [NBITS-1:0] r_data_out;
    logic             r_clkin2;
    logic             r_soc;
    logic             r_valid;
    logic             r_busy;
    logic             r_start_d;
    logic             r_din_s1;
    logic             r_din_s2;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [BIT_W-1:0] w_bitcnt_nxt;
    logic [NBITS-1:0] w_shreg_nxt;
    logic [NBITS-1:0] w_data_nxt;
    logic             w_clkin2_nxt;
    logic             w_soc_nxt;
    logic             w_valid_nxt;
    logic             w_busy_nxt;
    logic             w_start_edge;

    assign w_start_edge = start & ~r_start_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitcnt   <= '0;
            r_shreg    <= '0;
            r_data_out <= '0;
            r_clkin2   <= 1'b0;
            r_soc      <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_start_d  <= 1'b0;
            r_din_s1   <= 1'b0;
            r_din_s2   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_data_out <= w_data_nxt;
            r_clkin2   <= w_clkin2_nxt;
            r_soc      <= w_soc_nxt;
            r_valid    <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_start_d  <= start;
            r_din_s1   <= serial_din;
            r_din_s2   <= r_din_s1;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_data_nxt   = r_data_out;
        w_clkin2_nxt = 1'b0;
        w_soc_nxt    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt  = S_PRE;
                    w_cnt_nxt    = '0;
                    w_bitcnt_nxt = '0;
                    w_shreg_nxt  = '0;
                end
            end
            S_PRE: begin
                if (r_cnt == CNT_W'(PER - 1)) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                // Sample on the last cycle of each low phase
                if (r_cnt == CNT_W'(PER - 1)) begin
                    w_cnt_nxt    = '0;
                    w_shreg_nxt  = {r_shreg[NBITS-2:0], r_din_s2};
                    w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
                    if (r_bitcnt == BIT_W'(NBITS - 1)) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_PRE: begin
                w_busy_nxt   = 1'b1;
                w_clkin2_nxt = (w_cnt_nxt < CNT_W'(CLK_HALF));
            end
            S_SETUP: begin
                w_busy_nxt = 1'b1;
                w_soc_nxt  = 1'b1;
            end
            S_SHIFT: begin
                w_busy_nxt   = 1'b1;
                w_soc_nxt    = 1'b1;
                w_clkin2_nxt = (w_cnt_nxt < CNT_W'(CLK_HALF));
            end
            S_DONE: begin
                w_busy_nxt  = 1'b1;
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_shreg_nxt;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    assign clkin2         = r_clkin2;
    assign serial_out_cnt = r_soc;
    assign data_out       = r_data_out;
    assign data_valid     = r_valid;
    assign busy           = r_busy;

endmodule
